// File: rtl/hba_pkg.sv
// Shared HBA definitions: slot count, arbiter state encoding and the default
// watchdog limit. Imported by every block that arbitrates the HBA bus.
package hba_pkg;

  // Physical requester slots on the bus; NUM_MASTERS may use fewer of them.
  localparam int HBA_NUM_MASTER_SLOTS = 4;

  // Width of a slot index. The slot count is a power of two, so index
  // arithmetic wraps naturally.
  localparam int HBA_IDX_W = 2;

  // Default number of select-without-ack cycles before the watchdog fires.
  localparam int HBA_TIMEOUT_CYCLES_DEFAULT = 256;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWNED = 2'd1,
    ARB_TURN  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/hba_rr_pick.sv
// Combinational round-robin picker: given a request mask and the index that
// won last time, return the first requesting slot after it, searching
// cyclically. last_ptr itself is examined last, so it only wins again when
// nobody else is asking.
module hba_rr_pick
  import hba_pkg::*;
(
  input  logic [HBA_NUM_MASTER_SLOTS-1:0] req,
  input  logic [HBA_IDX_W-1:0]            last_ptr,
  output logic                            valid,
  output logic [HBA_NUM_MASTER_SLOTS-1:0] grant,
  output logic [HBA_IDX_W-1:0]            index
);

  // Cyclic first-hit search starting one slot after last_ptr.
  always_comb begin
    valid = 1'b0;
    grant = '0;
    index = '0;
    for (int off = 1; off <= HBA_NUM_MASTER_SLOTS; off++) begin
      logic [HBA_IDX_W-1:0] cand;
      // Slot count is 2**HBA_IDX_W, so the addition wraps modulo the slots.
      cand = last_ptr + HBA_IDX_W'(off);
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/hba_rr_arbiter.sv
// Round-robin HBA bus arbiter with a transfer watchdog.
//
// Request/grant protocol: a master raises hba_mrequest[i] and holds it for
// the whole transaction. hba_mgrant[i] rises one cycle after the request is
// sampled in IDLE and stays high while the master keeps its request or while
// hba_select is high. Releasing both request and select ends ownership; one
// dead TURN cycle follows before the next arbitration. The slave side
// completes a beat with hba_xferack; if none arrives within TIMEOUT_CYCLES
// cycles of continuous select, hba_xferack_timeout stands in for it for one
// cycle and the error flags record which master stalled.
module hba_rr_arbiter
  import hba_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = HBA_TIMEOUT_CYCLES_DEFAULT,
  parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                            hba_clk,
  input  logic                            hba_reset,
  input  logic [HBA_NUM_MASTER_SLOTS-1:0] hba_mrequest,
  input  logic                            hba_select,
  input  logic                            hba_xferack,
  output logic [HBA_NUM_MASTER_SLOTS-1:0] hba_mgrant,
  output logic                            hba_xferack_timeout,
  output logic                            arb_busy,
  output logic                            err_timeout,
  output logic [HBA_IDX_W-1:0]            err_master,
  input  logic                            err_clear
);

  // Slots at or above NUM_MASTERS are unused and their requests are ignored.
  localparam logic [HBA_NUM_MASTER_SLOTS-1:0] REQ_MASK =
    HBA_NUM_MASTER_SLOTS'((1 << NUM_MASTERS) - 1);
  // Starting the pointer on the highest used slot makes master 0 win first.
  localparam logic [HBA_IDX_W-1:0] PTR_RESET = HBA_IDX_W'(NUM_MASTERS - 1);
  localparam logic [CNT_WIDTH-1:0] WD_LAST   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] WD_MAX    = CNT_WIDTH'(TIMEOUT_CYCLES);

  arb_state_t                      state;
  logic [HBA_IDX_W-1:0]            last_ptr;
  logic [CNT_WIDTH-1:0]            wd_cnt;

  logic [HBA_NUM_MASTER_SLOTS-1:0] req_valid;
  logic                            pick_valid;
  logic [HBA_NUM_MASTER_SLOTS-1:0] pick_grant;
  logic [HBA_IDX_W-1:0]            pick_index;
  logic                            owner_req;
  logic                            release_bus;
  logic                            wd_fire;

  assign req_valid = hba_mrequest & REQ_MASK;

  // While OWNED, last_ptr is the index of the current owner.
  assign owner_req   = hba_mrequest[last_ptr];
  assign release_bus = !owner_req && !hba_select;

  // Fires on the TIMEOUT_CYCLES-th consecutive select-without-ack cycle;
  // a real ack in the same cycle wins.
  assign wd_fire = (state == ARB_OWNED) && hba_select && !hba_xferack &&
                   (wd_cnt == WD_LAST);

  hba_rr_pick u_pick (
    .req      (req_valid),
    .last_ptr (last_ptr),
    .valid    (pick_valid),
    .grant    (pick_grant),
    .index    (pick_index)
  );

  // Arbitration FSM, watchdog counter and sticky error capture.
  always_ff @(posedge hba_clk or posedge hba_reset) begin
    if (hba_reset) begin
      state               <= ARB_IDLE;
      hba_mgrant          <= '0;
      hba_xferack_timeout <= 1'b0;
      arb_busy            <= 1'b0;
      err_timeout         <= 1'b0;
      err_master          <= '0;
      last_ptr            <= PTR_RESET;
      wd_cnt              <= '0;
    end else begin
      hba_xferack_timeout <= 1'b0;

      // Clear first so a simultaneous watchdog fire below overrides it.
      if (err_clear) begin
        err_timeout <= 1'b0;
      end

      case (state)
        ARB_IDLE: begin
          wd_cnt <= '0;
          if (pick_valid) begin
            hba_mgrant <= pick_grant;
            last_ptr   <= pick_index;
            arb_busy   <= 1'b1;
            state      <= ARB_OWNED;
          end
        end

        ARB_OWNED: begin
          if (!hba_select || hba_xferack) begin
            wd_cnt <= '0;
          end else if (wd_fire) begin
            wd_cnt              <= '0;
            hba_xferack_timeout <= 1'b1;
            err_timeout         <= 1'b1;
            err_master          <= last_ptr;
          end else if (wd_cnt != WD_MAX) begin
            wd_cnt <= wd_cnt + 1'b1;
          end

          if (release_bus) begin
            hba_mgrant <= '0;
            arb_busy   <= 1'b0;
            wd_cnt     <= '0;
            state      <= ARB_TURN;
          end
        end

        ARB_TURN: begin
          wd_cnt <= '0;
          state  <= ARB_IDLE;
        end

        default: begin
          hba_mgrant <= '0;
          arb_busy   <= 1'b0;
          wd_cnt     <= '0;
          state      <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hba_rr_arbiter.sv
// Bench for hba_rr_arbiter: directed scenarios plus randomized traffic,
// all checked against a transaction-level reference model.
module tb_hba_rr_arbiter;

  localparam int NM = 4;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst;
  logic [3:0] mreq;
  logic       sel;
  logic       ack;
  logic       clr;
  logic [3:0] mgrant;
  logic       to_ack;
  logic       busy;
  logic       err_to;
  logic [1:0] err_m;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hba_rr_arbiter #(
    .NUM_MASTERS    (NM),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .hba_clk             (clk),
    .hba_reset           (rst),
    .hba_mrequest        (mreq),
    .hba_select          (sel),
    .hba_xferack         (ack),
    .hba_mgrant          (mgrant),
    .hba_xferack_timeout (to_ack),
    .arb_busy            (busy),
    .err_timeout         (err_to),
    .err_master          (err_m),
    .err_clear           (clr)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owner = -1 when the bus is free; dead marks the idle gap after a release.
  int         m_owner;
  int         m_dead;
  int         m_last;
  int         m_wd;
  logic       m_err;
  int         m_err_master;
  logic [8:0] exp_q[$];

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_owner      = -1;
      m_dead       = 0;
      m_last       = NM - 1;
      m_wd         = 0;
      m_err        = 1'b0;
      m_err_master = 0;
      exp_q.delete();
    end else begin
      logic       pulse;
      logic [3:0] g;
      pulse = 1'b0;
      if (clr) m_err = 1'b0;
      if (m_owner >= 0) begin
        if (!sel || ack) m_wd = 0;
        else if (m_wd == TO - 1) begin
          m_wd = 0;
          pulse = 1'b1;
          m_err = 1'b1;
          m_err_master = m_owner;
        end else m_wd++;
        if (!mreq[m_owner] && !sel) begin
          m_owner = -1;
          m_dead  = 1;
          m_wd    = 0;
        end
      end else if (m_dead != 0) begin
        m_dead = 0;
      end else begin
        for (int i = 1; i <= NM; i++) begin
          int c;
          c = (m_last + i) % NM;
          if (m_owner < 0 && mreq[c]) begin
            m_owner = c;
            m_last  = c;
          end
        end
      end
      g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
      exp_q.push_back({2'(m_err_master), m_err, pulse, (m_owner >= 0), g});
    end
  end

  // Scoreboard: compare every post-edge output word with the model.
  initial forever begin
    @(negedge clk);
    if (!rst && exp_q.size() > 0) begin
      logic [8:0] e;
      e = exp_q.pop_front();
      check("scoreboard", {23'b0, err_m, err_to, to_ack, busy, mgrant}, {23'b0, e});
      check("onehot0", {31'b0, $onehot0(mgrant)}, 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  logic [3:0] req_v;

  task automatic step(input logic [3:0] r, input logic s, input logic a, input logic c);
    mreq = r;
    sel  = s;
    ack  = a;
    clr  = c;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req_v = 4'b0000;
    mreq  = 4'b0000;
    sel   = 1'b0;
    ack   = 1'b0;
    clr   = 1'b0;
    #1;
    check("rst_grant", {28'b0, mgrant}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_to_ack", {31'b0, to_ack}, 32'd0);
    check("rst_err", {29'b0, err_m, err_to}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_grant(output int idx, output int cyc);
    idx = -1;
    cyc = 0;
    while (mgrant == 4'b0000 && cyc < 20) begin
      step(req_v, 1'b0, 1'b0, 1'b0);
      cyc++;
    end
    check("grant_seen", {31'b0, |mgrant}, 32'd1);
    for (int i = 0; i < NM; i++) if (mgrant[i]) idx = i;
  endtask

  // One short transfer by the owner, then release; optionally re-request.
  task automatic transfer(input int idx, input bit rerequest);
    step(req_v, 1'b1, 1'b0, 1'b0);
    step(req_v, 1'b1, 1'b1, 1'b0);
    req_v[idx] = 1'b0;
    step(req_v, 1'b0, 1'b0, 1'b0);
    if (rerequest) req_v[idx] = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int idx;
  int cyc;
  int n;
  int rr_exp[5] = '{0, 1, 2, 3, 0};

  initial begin
    do_reset();

    // Single master: latency 1, then release into the dead cycle.
    req_v = 4'b0001;
    step(req_v, 1'b0, 1'b0, 1'b0);
    check("single_grant", {28'b0, mgrant}, 32'h1);
    req_v = 4'b0000;
    step(req_v, 1'b0, 1'b0, 1'b0);
    check("single_release", {28'b0, mgrant}, 32'h0);
    step(req_v, 1'b0, 1'b0, 1'b0);
    step(req_v, 1'b0, 1'b0, 1'b0);

    // All four requesting: rotation 0,1,2,3,0 with a TURN + IDLE gap.
    do_reset();
    req_v = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(idx, cyc);
      check("rr_order", idx, rr_exp[k]);
      if (k > 0) check("rr_gap", cyc, 32'd2);
      transfer(idx, 1'b1);
    end
    req_v = 4'b0000;
    repeat (3) step(req_v, 1'b0, 1'b0, 1'b0);

    // 0110 from reset: master 1 first; master 2 waits while select is high.
    do_reset();
    req_v = 4'b0110;
    wait_grant(idx, cyc);
    check("pair_first", idx, 32'd1);
    repeat (3) begin
      step(req_v, 1'b1, 1'b0, 1'b0);
      check("pair_hold", {28'b0, mgrant}, 32'h2);
    end
    req_v = 4'b0100;
    step(req_v, 1'b1, 1'b1, 1'b0);
    check("pair_hold_sel", {28'b0, mgrant}, 32'h2);
    step(req_v, 1'b0, 1'b0, 1'b0);
    wait_grant(idx, cyc);
    check("pair_second", idx, 32'd2);
    req_v = 4'b0000;
    repeat (3) step(req_v, 1'b0, 1'b0, 1'b0);

    // Watchdog fires after TO cycles of select without ack.
    do_reset();
    req_v = 4'b0001;
    wait_grant(idx, cyc);
    n = 0;
    while (!to_ack && n < 20) begin
      step(req_v, 1'b1, 1'b0, 1'b0);
      n++;
    end
    check("to_latency", n, TO);
    check("to_err", {31'b0, err_to}, 32'd1);
    check("to_master", {30'b0, err_m}, 32'd0);
    req_v = 4'b0000;
    step(req_v, 1'b0, 1'b0, 1'b0);
    check("to_single", {31'b0, to_ack}, 32'd0);
    step(req_v, 1'b0, 1'b0, 1'b1);
    check("to_clear", {31'b0, err_to}, 32'd0);
    step(req_v, 1'b0, 1'b0, 1'b0);

    // Slave ack on the TO-th cycle beats the watchdog.
    do_reset();
    req_v = 4'b0001;
    wait_grant(idx, cyc);
    repeat (TO - 1) step(req_v, 1'b1, 1'b0, 1'b0);
    step(req_v, 1'b1, 1'b1, 1'b0);
    check("ack_wins_pulse", {31'b0, to_ack}, 32'd0);
    check("ack_wins_err", {31'b0, err_to}, 32'd0);
    step(req_v, 1'b1, 1'b0, 1'b0);
    check("ack_wins_after", {31'b0, to_ack}, 32'd0);
    req_v = 4'b0000;
    repeat (3) step(req_v, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-transfer drops the grant at once.
    do_reset();
    req_v = 4'b0001;
    wait_grant(idx, cyc);
    step(req_v, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_grant", {28'b0, mgrant}, 32'h0);
    check("async_busy", {31'b0, busy}, 32'd0);
    check("async_to_ack", {31'b0, to_ack}, 32'd0);
    @(negedge clk);
    sel   = 1'b0;
    req_v = 4'b0011;
    rst   = 1'b0;
    wait_grant(idx, cyc);
    check("async_regrant", idx, 32'd0);

    // Randomized traffic against the model.
    do_reset();
    repeat (3000) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

endmodule
